// File: rtl/pipe_sequencer_pkg.sv
// Shared types and defaults for the pipeline run controller.
// State encoding plus default sizing used by pipe_sequencer and its bench.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam int W_DEF            = 5;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int CNT_B_DEF        = 32;

    localparam logic [4:0] ENA_NONE  = 5'b00000;
    localparam logic [4:0] ENA_ALL   = 5'b11111;
    localparam logic [4:0] ENA_STALL = 5'b00111;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Control bundle between the debug/control side and the run controller.
// Enable order in vectors is {pc, if_id, id_ex, ex_mem, mem_wb}.
interface pipe_sequencer_if #(
    parameter int W     = 5,
    parameter int CNT_B = 32
);
    logic             start;
    logic             mode_step;
    logic             step;
    logic             halt_dec;
    logic             id_ex_MemRead;
    logic [W-1:0]     id_ex_rt;
    logic [W-1:0]     if_id_rs;
    logic [W-1:0]     if_id_rt;
    logic             ena_pc;
    logic             ena_if_id;
    logic             ena_id_ex;
    logic             ena_ex_mem;
    logic             ena_mem_wb;
    logic             bubble_id_ex;
    logic             running;
    logic             halted;
    logic [CNT_B-1:0] cycle_count;

    modport master (
        output start, mode_step, step, halt_dec,
        output id_ex_MemRead, id_ex_rt, if_id_rs, if_id_rt,
        input  ena_pc, ena_if_id, ena_id_ex, ena_ex_mem, ena_mem_wb,
        input  bubble_id_ex, running, halted, cycle_count
    );

    modport slave (
        input  start, mode_step, step, halt_dec,
        input  id_ex_MemRead, id_ex_rt, if_id_rs, if_id_rt,
        output ena_pc, ena_if_id, ena_id_ex, ena_ex_mem, ena_mem_wb,
        output bubble_id_ex, running, halted, cycle_count
    );

endinterface

// File: rtl/pipe_sequencer_step_edge_det.sv
// Rising-edge detector for the debug step request.
// Registers step every cycle; o_rise is high for one cycle per 0->1 edge.
module step_edge_det (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_step,
    output logic o_rise
);

    logic r_step_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= i_step;
        end
    end

    assign o_rise = i_step & ~r_step_q;

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline run controller: run/step/drain/halt plus load-use stall.
// Optional advance counter enabled by defining PIPE_SEQ_CYCLE_COUNT_EN.
module pipe_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int W            = W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_B        = CNT_B_DEF
) (
    input  logic             clk,
    input  logic             reset,
    pipe_sequencer_if.slave  bus
);

    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    state_t         r_state;
    state_t         w_next;
    logic [DCW-1:0] r_drain_cnt;
    logic           w_step_rise;
    logic           w_hazard;
    logic           w_adv;
    logic           w_front;
    logic           w_take_halt;
    logic [4:0]     w_ena;

    step_edge_det u_step_edge (
        .i_clk   (clk),
        .i_reset (reset),
        .i_step  (bus.step),
        .o_rise  (w_step_rise)
    );

    assign w_hazard = bus.id_ex_MemRead
                    & (bus.id_ex_rt != '0)
                    & ((bus.id_ex_rt == bus.if_id_rs)
                     | (bus.id_ex_rt == bus.if_id_rt));

    assign w_adv = (r_state == ST_RUN)
                 | ((r_state == ST_STEP) & w_step_rise)
                 | (r_state == ST_DRAIN);

    // Front-end advance: an instruction in IF/ID may be decoded this cycle
    assign w_front = w_adv
                   & ((r_state == ST_RUN) | (r_state == ST_STEP));

    assign w_take_halt = w_front & bus.halt_dec & ~w_hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain_cnt <= '0;
        end else if (w_take_halt) begin
            r_drain_cnt <= DCW'(DRAIN_CYCLES);
        end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = bus.mode_step ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                if (w_take_halt) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt <= DCW'(1)) begin
                    w_next = ST_HALTED;
                end
            end
            ST_HALTED: w_next = ST_HALTED;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ena            = ENA_NONE;
        bus.bubble_id_ex = 1'b0;
        bus.running      = 1'b0;
        bus.halted       = 1'b0;
        unique case (r_state)
            ST_IDLE: ;
            ST_RUN, ST_STEP: begin
                bus.running = 1'b1;
                if (w_front) begin
                    // Hazard and halt both freeze the front and inject a bubble
                    if (w_hazard || bus.halt_dec) begin
                        w_ena            = ENA_STALL;
                        bus.bubble_id_ex = 1'b1;
                    end else begin
                        w_ena = ENA_ALL;
                    end
                end
            end
            ST_DRAIN: begin
                bus.running      = 1'b1;
                w_ena            = ENA_STALL;
                bus.bubble_id_ex = 1'b1;
            end
            ST_HALTED: bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.ena_pc     = w_ena[4];
    assign bus.ena_if_id  = w_ena[3];
    assign bus.ena_id_ex  = w_ena[2];
    assign bus.ena_ex_mem = w_ena[1];
    assign bus.ena_mem_wb = w_ena[0];

`ifdef PIPE_SEQ_CYCLE_COUNT_EN
    logic [CNT_B-1:0] r_cycle_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (w_adv && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign bus.cycle_count = r_cycle_count;
`else
    assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer with an expected-result queue.
// Honours PIPE_SEQ_CYCLE_COUNT_EN for the cycle_count expectation.
module tb_pipe_sequencer;
    import pipe_ctrl_pkg::*;

    localparam int W     = 5;
    localparam int CNT_B = 32;
`ifdef PIPE_SEQ_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        string            tag;
        logic [4:0]       ena;
        logic             bub;
        logic             run;
        logic             hlt;
        logic [CNT_B-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       w_ena;
    logic [CNT_B-1:0] m_cnt = '0;
    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    pipe_sequencer_if #(.W(W), .CNT_B(CNT_B)) bus ();

    pipe_sequencer #(
        .W            (W),
        .DRAIN_CYCLES (3),
        .CNT_B        (CNT_B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign w_ena = {bus.ena_pc, bus.ena_if_id, bus.ena_id_ex,
                    bus.ena_ex_mem, bus.ena_mem_wb};

    task automatic chk(input string tag, input logic [4:0] ena,
                       input logic bub, input logic run, input logic hlt);
        exp_t e;
        e.tag = tag;
        e.ena = ena;
        e.bub = bub;
        e.run = run;
        e.hlt = hlt;
        e.cnt = CNT_EN ? m_cnt : '0;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (w_ena === e.ena) else begin
            errors++;
            $error("FAIL %s ena got %b exp %b", e.tag, w_ena, e.ena);
        end
        checks++;
        assert (bus.bubble_id_ex === e.bub) else begin
            errors++;
            $error("FAIL %s bubble got %b exp %b", e.tag, bus.bubble_id_ex, e.bub);
        end
        checks++;
        assert (bus.running === e.run) else begin
            errors++;
            $error("FAIL %s running got %b exp %b", e.tag, bus.running, e.run);
        end
        checks++;
        assert (bus.halted === e.hlt) else begin
            errors++;
            $error("FAIL %s halted got %b exp %b", e.tag, bus.halted, e.hlt);
        end
        checks++;
        assert (bus.cycle_count === e.cnt) else begin
            errors++;
            $error("FAIL %s cycle_count got %0d exp %0d", e.tag, bus.cycle_count, e.cnt);
        end
        if (ena[0] && (m_cnt != '1)) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.mode_step     = 1'b0;
        bus.step          = 1'b0;
        bus.halt_dec      = 1'b0;
        bus.id_ex_MemRead = 1'b0;
        bus.id_ex_rt      = '0;
        bus.if_id_rs      = '0;
        bus.if_id_rt      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("reset_idle", ENA_NONE, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        chk("idle_start", ENA_NONE, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        chk("run_all", ENA_ALL, 1'b0, 1'b1, 1'b0);

        bus.id_ex_MemRead = 1'b1;
        bus.id_ex_rt      = 5'd8;
        bus.if_id_rs      = 5'd8;
        bus.if_id_rt      = 5'd2;
        chk("haz_rs", ENA_STALL, 1'b1, 1'b1, 1'b0);
        bus.if_id_rs = 5'd3;
        bus.if_id_rt = 5'd8;
        chk("haz_rt", ENA_STALL, 1'b1, 1'b1, 1'b0);
        bus.id_ex_rt = 5'd0;
        bus.if_id_rs = 5'd0;
        bus.if_id_rt = 5'd0;
        chk("rt_zero", ENA_ALL, 1'b0, 1'b1, 1'b0);
        bus.id_ex_MemRead = 1'b0;
        bus.id_ex_rt      = 5'd8;
        bus.if_id_rs      = 5'd8;
        chk("no_load", ENA_ALL, 1'b0, 1'b1, 1'b0);

        bus.id_ex_MemRead = 1'b1;
        bus.halt_dec      = 1'b1;
        chk("haz_halt", ENA_STALL, 1'b1, 1'b1, 1'b0);
        bus.id_ex_MemRead = 1'b0;
        bus.halt_dec      = 1'b0;
        for (int i = 0; i < 3; i++) chk("run_pad", ENA_ALL, 1'b0, 1'b1, 1'b0);

        bus.halt_dec = 1'b1;
        chk("halt_dec", ENA_STALL, 1'b1, 1'b1, 1'b0);
        bus.halt_dec = 1'b0;
        for (int i = 0; i < 3; i++) chk("drain", ENA_STALL, 1'b1, 1'b1, 1'b0);

        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) chk("halted", ENA_NONE, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b0;
        checks++;
        assert (bus.cycle_count === (CNT_EN ? 32'd13 : 32'd0)) else begin
            errors++;
            $error("FAIL total_count got %0d exp %0d", bus.cycle_count,
                   CNT_EN ? 13 : 0);
        end

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = '0;
        bus.start     = 1'b1;
        bus.mode_step = 1'b1;
        chk("idle_again", ENA_NONE, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        chk("step_wait", ENA_NONE, 1'b0, 1'b1, 1'b0);
        bus.step = 1'b1;
        chk("step_edge", ENA_ALL, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) chk("step_held", ENA_NONE, 1'b0, 1'b1, 1'b0);
        bus.step = 1'b0;
        chk("step_low", ENA_NONE, 1'b0, 1'b1, 1'b0);
        bus.step = 1'b1;
        chk("step_edge2", ENA_ALL, 1'b0, 1'b1, 1'b0);
        bus.step = 1'b0;
        chk("step_low2", ENA_NONE, 1'b0, 1'b1, 1'b0);

        bus.id_ex_MemRead = 1'b1;
        bus.id_ex_rt      = 5'd4;
        bus.if_id_rs      = 5'd1;
        bus.if_id_rt      = 5'd4;
        bus.step          = 1'b1;
        chk("step_haz", ENA_STALL, 1'b1, 1'b1, 1'b0);
        bus.id_ex_MemRead = 1'b0;
        bus.step          = 1'b0;
        chk("step_low3", ENA_NONE, 1'b0, 1'b1, 1'b0);

        bus.step     = 1'b1;
        bus.halt_dec = 1'b1;
        chk("step_halt", ENA_STALL, 1'b1, 1'b1, 1'b0);
        bus.step     = 1'b0;
        bus.halt_dec = 1'b0;
        chk("drain_c3", ENA_STALL, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        chk("drain_c2", ENA_STALL, 1'b1, 1'b1, 1'b0);
        m_cnt = '0;
        chk("rst_drain", ENA_NONE, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("idle_final", ENA_NONE, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
